// File: rtl/attosoc_mem_arbiter.sv
// Two-master round-robin arbiter for one PicoRV32-native memory port.
// The grant is held until the slave completes, the master withdraws, or the watchdog fires.
module attosoc_mem_arbiter #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        grant,
  output logic        busy,
  output logic        timeout_flag,
  input  logic        err_clr
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam int unsigned WDW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [0:0]     state;
  logic           last;
  logic [WDW-1:0] wdog;
  logic           busy_i;
  logic           g_valid;
  logic           wd_hit;
  logic           done;

  // Slave-side outputs are forced to zero outside BUSY so reset blanks them at once.
  always_comb begin
    busy_i   = (state == S_BUSY);
    g_valid  = grant ? m1_valid : m0_valid;
    wd_hit   = (TIMEOUT != 0) && (wdog == WD_LAST) && !s_ready;
    done     = busy_i && g_valid && (s_ready || wd_hit);
    s_valid  = busy_i && g_valid;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m_rdata  = '0;
    if (busy_i) begin
      s_addr  = grant ? m1_addr  : m0_addr;
      s_wdata = grant ? m1_wdata : m0_wdata;
      s_wstrb = grant ? m1_wstrb : m0_wstrb;
      m_rdata = wd_hit ? ERR_RDATA : s_rdata;
    end
    m0_ready = done && !grant;
    m1_ready = done && grant;
    busy     = busy_i;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      grant        <= 1'b0;
      last         <= 1'b1;
      wdog         <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (done && wd_hit)
        timeout_flag <= 1'b1;
      else if (err_clr)
        timeout_flag <= 1'b0;

      if (state == S_IDLE) begin
        if (m0_valid || m1_valid) begin
          state <= S_BUSY;
          wdog  <= '0;
          grant <= (m0_valid && m1_valid) ? ~last : m1_valid;
        end
      end else begin
        // A withdrawn request is abandoned without touching the round-robin history.
        if (!g_valid) begin
          state <= S_IDLE;
        end else if (done) begin
          state <= S_IDLE;
          last  <= grant;
        end else begin
          wdog <= wdog + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_attosoc_mem_arbiter.sv
// Directed bench for attosoc_mem_arbiter with a short watchdog (TIMEOUT=4).
module tb_attosoc_mem_arbiter;

  logic        clk;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        grant, busy, timeout_flag, err_clr;

  int vecs;
  int errs;

  attosoc_mem_arbiter #(.TIMEOUT(4), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready),
    .m_rdata(m_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .busy(busy), .timeout_flag(timeout_flag), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) cyc();
    #1;
    vecs++; if (s_valid !== 1'b0 || busy !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0)
      begin errs++; $display("FAIL reset_idle: s_valid=%b busy=%b r0=%b r1=%b, expected all 0", s_valid, busy, m0_ready, m1_ready); end
    vecs++; if (grant !== 1'b0 || timeout_flag !== 1'b0 || s_addr !== 32'h0 || m_rdata !== 32'h0)
      begin errs++; $display("FAIL reset_outs: grant=%b flag=%b s_addr=%h m_rdata=%h, expected 0", grant, timeout_flag, s_addr, m_rdata); end
    // Release, then let M0 time out so the sticky flag is set before reset is reapplied.
    cyc();
    resetn = 1'b1; m0_valid = 1'b1; m0_addr = 32'h0000_0100; s_ready = 1'b0;
    for (int k = 1; k <= 4; k++) cyc();
    #1;
    vecs++; if (m0_ready !== 1'b1 || m_rdata !== 32'hDEAD_BEEF)
      begin errs++; $display("FAIL reset_pre_timeout: m0_ready=%b m_rdata=%h, expected 1 deadbeef", m0_ready, m_rdata); end
    cyc(); cyc();
    #1;
    vecs++; if (busy !== 1'b1 || s_valid !== 1'b1 || timeout_flag !== 1'b1)
      begin errs++; $display("FAIL reset_pre_busy: busy=%b s_valid=%b flag=%b, expected 1 1 1", busy, s_valid, timeout_flag); end
    #1 resetn = 1'b0;
    #1;
    vecs++; if (s_valid !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0 || busy !== 1'b0 || timeout_flag !== 1'b0)
      begin errs++; $display("FAIL reset_async: s_valid=%b r0=%b r1=%b busy=%b flag=%b, expected all 0", s_valid, m0_ready, m1_ready, busy, timeout_flag); end
    m1_valid = 1'b1; m1_addr = 32'h0000_0200; s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
    cyc();
    resetn = 1'b1;
    cyc();
    #1;
    vecs++; if (busy !== 1'b1 || grant !== 1'b0 || m0_ready !== 1'b1 || m1_ready !== 1'b0)
      begin errs++; $display("FAIL reset_first_grant: busy=%b grant=%b r0=%b r1=%b, expected 1 0 1 0", busy, grant, m0_ready, m1_ready); end
    cyc();
    m0_valid = 1'b0; m1_valid = 1'b0;
  endtask

  task automatic test_single_read();
    cyc();
    m0_valid = 1'b1; m0_addr = 32'h0000_0010; m0_wstrb = 4'b0000; s_ready = 1'b1; s_rdata = 32'h1234_5678;
    #1;
    vecs++; if (s_valid !== 1'b0 || m0_ready !== 1'b0)
      begin errs++; $display("FAIL read_cycleN: s_valid=%b m0_ready=%b, expected 0 0", s_valid, m0_ready); end
    cyc();
    #1;
    vecs++; if (s_valid !== 1'b1 || s_addr !== 32'h0000_0010 || s_wstrb !== 4'b0000)
      begin errs++; $display("FAIL read_slave: s_valid=%b s_addr=%h s_wstrb=%b, expected 1 00000010 0000", s_valid, s_addr, s_wstrb); end
    vecs++; if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || m_rdata !== 32'h1234_5678)
      begin errs++; $display("FAIL read_ready: r0=%b r1=%b m_rdata=%h, expected 1 0 12345678", m0_ready, m1_ready, m_rdata); end
    cyc();
    m0_valid = 1'b0;
    #1;
    vecs++; if (m0_ready !== 1'b0 || busy !== 1'b0)
      begin errs++; $display("FAIL read_pulse: m0_ready=%b busy=%b, expected 0 0", m0_ready, busy); end
  endtask

  task automatic test_back_to_back();
    logic eb, eg;
    cyc();
    m0_valid = 1'b1; m1_valid = 1'b1; m0_addr = 32'h0000_0A00; m1_addr = 32'h0000_0B00; s_ready = 1'b1;
    // Last completion was M0, so M1 leads the alternation.
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 8) begin m0_valid = 1'b0; m1_valid = 1'b0; end
      #1;
      eb = (k % 2 == 1);
      eg = (((k - 1) / 2) % 2 == 0);
      vecs++; if (s_valid !== eb || m0_ready !== (eb && !eg) || m1_ready !== (eb && eg))
        begin errs++; $display("FAIL b2b_k%0d: s_valid=%b r0=%b r1=%b, expected %b %b %b", k, s_valid, m0_ready, m1_ready, eb, eb && !eg, eb && eg); end
      if (eb) begin
        vecs++; if (grant !== eg || s_addr !== (eg ? 32'h0000_0B00 : 32'h0000_0A00))
          begin errs++; $display("FAIL b2b_grant_k%0d: grant=%b s_addr=%h, expected %b", k, grant, s_addr, eg); end
      end
    end
  endtask

  task automatic test_wait_states();
    cyc();
    m1_valid = 1'b1; m1_addr = 32'h0200_0000; m1_wdata = 32'h0000_00A5; m1_wstrb = 4'b0001;
    s_ready = 1'b0; s_rdata = 32'hCAFE_0001;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      if (k == 1) begin m0_valid = 1'b1; m0_addr = 32'h0000_0040; m0_wstrb = 4'b0000; end
      s_ready = (k == 4);
      #1;
      vecs++; if (busy !== 1'b1 || grant !== 1'b1 || s_valid !== 1'b1 || s_wstrb !== 4'b0001 || s_addr !== 32'h0200_0000 || s_wdata !== 32'h0000_00A5)
        begin errs++; $display("FAIL wait_hold_k%0d: busy=%b grant=%b s_valid=%b s_wstrb=%b s_addr=%h s_wdata=%h", k, busy, grant, s_valid, s_wstrb, s_addr, s_wdata); end
      vecs++; if (m1_ready !== (k == 4) || m0_ready !== 1'b0)
        begin errs++; $display("FAIL wait_ready_k%0d: r1=%b r0=%b, expected %b 0", k, m1_ready, m0_ready, k == 4); end
    end
    vecs++; if (m_rdata !== 32'hCAFE_0001)
      begin errs++; $display("FAIL wait_rdata: m_rdata=%h, expected cafe0001", m_rdata); end
    cyc();
    m1_valid = 1'b0;
    #1;
    vecs++; if (busy !== 1'b0 || m1_ready !== 1'b0 || timeout_flag !== 1'b0)
      begin errs++; $display("FAIL wait_after: busy=%b r1=%b flag=%b, expected 0 0 0", busy, m1_ready, timeout_flag); end
    cyc();
    #1;
    vecs++; if (busy !== 1'b1 || grant !== 1'b0 || m0_ready !== 1'b1 || s_addr !== 32'h0000_0040)
      begin errs++; $display("FAIL wait_m0_next: busy=%b grant=%b r0=%b s_addr=%h, expected 1 0 1 00000040", busy, grant, m0_ready, s_addr); end
    cyc();
    m0_valid = 1'b0;
  endtask

  task automatic test_timeout();
    cyc();
    m0_valid = 1'b1; m0_addr = 32'h0000_0300; s_ready = 1'b0; s_rdata = 32'h1111_1111;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      #1;
      vecs++; if (busy !== 1'b1 || m0_ready !== (k == 4) || timeout_flag !== 1'b0)
        begin errs++; $display("FAIL to_k%0d: busy=%b r0=%b flag=%b, expected 1 %b 0", k, busy, m0_ready, timeout_flag, k == 4); end
    end
    vecs++; if (m_rdata !== 32'hDEAD_BEEF)
      begin errs++; $display("FAIL to_rdata: m_rdata=%h, expected deadbeef", m_rdata); end
    cyc();
    m0_valid = 1'b0;
    #1;
    vecs++; if (timeout_flag !== 1'b1 || busy !== 1'b0)
      begin errs++; $display("FAIL to_flag_set: flag=%b busy=%b, expected 1 0", timeout_flag, busy); end
    cyc();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    #1;
    vecs++; if (timeout_flag !== 1'b0)
      begin errs++; $display("FAIL to_flag_clr: flag=%b, expected 0", timeout_flag); end
    // Timeout with err_clr held high throughout: the set must win.
    m0_valid = 1'b1; err_clr = 1'b1;
    for (int k = 1; k <= 5; k++) cyc();
    m0_valid = 1'b0; err_clr = 1'b0;
    #1;
    vecs++; if (timeout_flag !== 1'b1)
      begin errs++; $display("FAIL to_set_wins: flag=%b, expected 1", timeout_flag); end
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
  endtask

  task automatic test_abandon();
    cyc();
    m1_valid = 1'b1; m1_addr = 32'h0000_0500; s_ready = 1'b0;
    cyc();
    #1;
    vecs++; if (busy !== 1'b1 || grant !== 1'b1 || s_valid !== 1'b1)
      begin errs++; $display("FAIL ab_granted: busy=%b grant=%b s_valid=%b, expected 1 1 1", busy, grant, s_valid); end
    cyc();
    m1_valid = 1'b0; s_ready = 1'b1;
    #1;
    vecs++; if (s_valid !== 1'b0 || m1_ready !== 1'b0 || m0_ready !== 1'b0)
      begin errs++; $display("FAIL ab_drop: s_valid=%b r1=%b r0=%b, expected 0 0 0", s_valid, m1_ready, m0_ready); end
    cyc();
    m0_valid = 1'b1; m1_valid = 1'b1;
    #1;
    vecs++; if (busy !== 1'b0 || m1_ready !== 1'b0)
      begin errs++; $display("FAIL ab_idle: busy=%b r1=%b, expected 0 0", busy, m1_ready); end
    cyc();
    #1;
    vecs++; if (grant !== 1'b1 || m1_ready !== 1'b1 || m0_ready !== 1'b0)
      begin errs++; $display("FAIL ab_tie: grant=%b r1=%b r0=%b, expected 1 1 0", grant, m1_ready, m0_ready); end
    cyc();
    m0_valid = 1'b0; m1_valid = 1'b0;
  endtask

  initial begin
    vecs = 0; errs = 0;
    resetn = 1'b0; err_clr = 1'b0;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready = 1'b0; s_rdata = '0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_wait_states();
    test_timeout();
    test_abandon();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
